branch_ctrl: RTL and testbench

Branch resolution controller for the CARPCore execute stage.
- Accepts one conditional branch at a time from issue.
- Sequences the shared combinational branch comparator and checks the outcome against the fetch-time prediction.
- Trains a small bimodal history table (BHT) that fetch reads for predictions.
- On a mispredict, raises a flush pulse and a redirect request to fetch, held until fetch accepts it.

---
 rtl/branch_ctrl.sv | 169 ++++++++++++++++
 tb/tb_branch_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Execute-stage branch resolver: accept -> EVAL next cycle -> redirect/flush the cycle after on mispredict.
// One branch in flight; br_ready_o low until the redirect is taken by fetch or killed by flush_i.
package branch_ctrl_pkg;
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_op_e;
endpackage

module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        br_valid_i,
  output logic        br_ready_o,
  input  branch_op_e  br_op_i,
  input  logic [31:0] br_pc_i,
  input  logic [31:0] br_imm_i,
  input  logic        br_pred_taken_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output branch_op_e  cmp_op_o,
  output logic [31:0] cmp_rs1_o,
  output logic [31:0] cmp_rs2_o,
  input  logic        cmp_taken_i,
  input  logic        flush_i,
  output logic        flush_o,
  output logic        redirect_valid_o,
  input  logic        redirect_ready_i,
  output logic [31:0] redirect_pc_o,
  input  logic [31:0] lookup_pc_i,
  output logic        lookup_taken_o,
  output logic [31:0] mispredict_cnt_o,
  output logic [31:0] branch_cnt_o
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_e;

  state_e      state_q, state_d;
  branch_op_e  op_q, op_d;
  logic [31:0] pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic        pred_q, pred_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        first_q, first_d;
  logic [31:0] mis_cnt_q, mis_cnt_d, br_cnt_q, br_cnt_d;
  logic [1:0]  bht_q [BHT_ENTRIES];
  logic [1:0]  bht_d [BHT_ENTRIES];

  logic             op_known, taken;
  logic [31:0]      target;
  logic [IDX_W-1:0] upd_idx;
  logic             unused_lookup_bits;

  always_comb begin
    op_known = op_q inside {BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU};
    taken    = op_known && cmp_taken_i;
    target   = taken ? (pc_q + imm_q) : (pc_q + 32'd4);
    upd_idx  = pc_q[IDX_W+1:2];

    state_d          = state_q;
    op_d             = op_q;
    pc_d             = pc_q;
    imm_d            = imm_q;
    rs1_d            = rs1_q;
    rs2_d            = rs2_q;
    pred_d           = pred_q;
    redir_pc_d       = redir_pc_q;
    first_d          = first_q;
    mis_cnt_d        = mis_cnt_q;
    br_cnt_d         = br_cnt_q;
    bht_d            = bht_q;
    br_ready_o       = 1'b0;
    redirect_valid_o = 1'b0;
    flush_o          = 1'b0;

    case (state_q)
      IDLE: begin
        br_ready_o = !flush_i;
        if (br_valid_i && br_ready_o) begin
          op_d    = br_op_i;
          pc_d    = br_pc_i;
          imm_d   = br_imm_i;
          pred_d  = br_pred_taken_i;
          rs1_d   = rs1_data_i;
          rs2_d   = rs2_data_i;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // A kill here discards the branch entirely: no training, no stats.
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
          if (op_known) begin
            if (taken && bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
            else if (!taken && bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
          end
          if (taken != pred_q) begin
            if (mis_cnt_q != 32'hFFFF_FFFF) mis_cnt_d = mis_cnt_q + 32'd1;
            redir_pc_d = target;
            first_d    = 1'b1;
            state_d    = REDIRECT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        flush_o          = first_q && !flush_i;
        first_d          = 1'b0;
        if (flush_i || redirect_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_q       <= BR_BEQ;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      pred_q     <= 1'b0;
      redir_pc_q <= '0;
      first_q    <= 1'b0;
      mis_cnt_q  <= '0;
      br_cnt_q   <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      pred_q     <= pred_d;
      redir_pc_q <= redir_pc_d;
      first_q    <= first_d;
      mis_cnt_q  <= mis_cnt_d;
      br_cnt_q   <= br_cnt_d;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= bht_d[i];
    end
  end

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign lookup_taken_o     = bht_q[lookup_pc_i[IDX_W+1:2]][1];
  assign unused_lookup_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};

  assign cmp_op_o         = op_q;
  assign cmp_rs1_o        = rs1_q;
  assign cmp_rs2_o        = rs2_q;
  assign redirect_pc_o    = redir_pc_q;
  assign mispredict_cnt_o = mis_cnt_q;
  assign branch_cnt_o     = br_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl; includes a behavioural comparator on the cmp_* port.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_ready;
  branch_op_e  br_op = BR_BEQ;
  logic [31:0] br_pc = '0, br_imm = '0, rs1 = '0, rs2 = '0;
  logic        br_pred = 1'b0;
  branch_op_e  cmp_op;
  logic [31:0] cmp_rs1, cmp_rs2;
  logic        cmp_taken;
  logic        flush_in = 1'b0;
  logic        flush_out;
  logic        rv;
  logic        rr = 1'b0;
  logic [31:0] rpc;
  logic [31:0] lookup_pc = '0;
  logic        lookup_taken;
  logic [31:0] mis_cnt, br_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Undefined ops deliberately report "taken" so the DUT's masking is visible.
  always_comb begin
    cmp_taken = 1'b1;
    case (cmp_op)
      BR_BEQ:  cmp_taken = (cmp_rs1 == cmp_rs2);
      BR_BNE:  cmp_taken = (cmp_rs1 != cmp_rs2);
      BR_BLT:  cmp_taken = ($signed(cmp_rs1) < $signed(cmp_rs2));
      BR_BGE:  cmp_taken = ($signed(cmp_rs1) >= $signed(cmp_rs2));
      BR_BLTU: cmp_taken = (cmp_rs1 < cmp_rs2);
      BR_BGEU: cmp_taken = (cmp_rs1 >= cmp_rs2);
      default: cmp_taken = 1'b1;
    endcase
  end

  branch_ctrl #(.BHT_ENTRIES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .br_valid_i(br_valid), .br_ready_o(br_ready), .br_op_i(br_op),
    .br_pc_i(br_pc), .br_imm_i(br_imm), .br_pred_taken_i(br_pred),
    .rs1_data_i(rs1), .rs2_data_i(rs2),
    .cmp_op_o(cmp_op), .cmp_rs1_o(cmp_rs1), .cmp_rs2_o(cmp_rs2), .cmp_taken_i(cmp_taken),
    .flush_i(flush_in), .flush_o(flush_out),
    .redirect_valid_o(rv), .redirect_ready_i(rr), .redirect_pc_o(rpc),
    .lookup_pc_i(lookup_pc), .lookup_taken_o(lookup_taken),
    .mispredict_cnt_o(mis_cnt), .branch_cnt_o(br_cnt)
  );

  // Entered and left at a falling edge; returns in the EVAL cycle.
  task automatic send(input branch_op_e op, input logic [31:0] pc, input logic [31:0] imm,
                      input logic pred, input logic [31:0] a, input logic [31:0] b);
    br_valid = 1'b1; br_op = op; br_pc = pc; br_imm = imm; br_pred = pred; rs1 = a; rs2 = b;
    @(posedge clk);
    @(negedge clk);
    br_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (br_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", br_ready); end
    n_cmp++; if (rv !== 1'b0) begin n_err++; $display("FAIL rst_rv: got %b want 0", rv); end
    n_cmp++; if (flush_out !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %b want 0", flush_out); end
    n_cmp++; if (mis_cnt !== 32'd0) begin n_err++; $display("FAIL rst_mis: got %h want 0", mis_cnt); end
    n_cmp++; if (br_cnt !== 32'd0) begin n_err++; $display("FAIL rst_br: got %h want 0", br_cnt); end
    n_cmp++; if (rpc !== 32'd0) begin n_err++; $display("FAIL rst_rpc: got %h want 0", rpc); end
    n_cmp++; if (cmp_rs1 !== 32'd0) begin n_err++; $display("FAIL rst_rs1: got %h want 0", cmp_rs1); end
    for (int i = 0; i < 16; i++) begin
      lookup_pc = i << 2;
      #1;
      n_cmp++; if (lookup_taken !== 1'b0) begin n_err++; $display("FAIL rst_bht[%0d]: got %b want 0", i, lookup_taken); end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mispredict();
    rr = 1'b1; lookup_pc = 32'h100;
    send(BR_BEQ, 32'h100, 32'h40, 1'b0, 32'd5, 32'd5);
    n_cmp++; if (br_ready !== 1'b0) begin n_err++; $display("FAIL mp_eval_ready: got %b want 0", br_ready); end
    n_cmp++; if (rv !== 1'b0) begin n_err++; $display("FAIL mp_eval_rv: got %b want 0", rv); end
    n_cmp++; if (cmp_op !== BR_BEQ) begin n_err++; $display("FAIL mp_cmp_op: got %0d want 0", cmp_op); end
    n_cmp++; if (cmp_rs1 !== 32'd5 || cmp_rs2 !== 32'd5) begin n_err++; $display("FAIL mp_cmp_ops: got %h/%h want 5/5", cmp_rs1, cmp_rs2); end
    n_cmp++; if (lookup_taken !== 1'b0) begin n_err++; $display("FAIL mp_same_cycle_lookup: got %b want 0", lookup_taken); end
    @(negedge clk);
    n_cmp++; if (rv !== 1'b1) begin n_err++; $display("FAIL mp_rv: got %b want 1", rv); end
    n_cmp++; if (flush_out !== 1'b1) begin n_err++; $display("FAIL mp_flush: got %b want 1", flush_out); end
    n_cmp++; if (rpc !== 32'h140) begin n_err++; $display("FAIL mp_rpc: got %h want 140", rpc); end
    n_cmp++; if (mis_cnt !== 32'd1) begin n_err++; $display("FAIL mp_mis: got %0d want 1", mis_cnt); end
    n_cmp++; if (br_cnt !== 32'd1) begin n_err++; $display("FAIL mp_br: got %0d want 1", br_cnt); end
    n_cmp++; if (lookup_taken !== 1'b1) begin n_err++; $display("FAIL mp_bht0: got %b want 1", lookup_taken); end
    @(negedge clk);
    n_cmp++; if (rv !== 1'b0 || flush_out !== 1'b0) begin n_err++; $display("FAIL mp_done: got rv=%b fl=%b want 0/0", rv, flush_out); end
    n_cmp++; if (br_ready !== 1'b1) begin n_err++; $display("FAIL mp_idle_ready: got %b want 1", br_ready); end
  endtask

  task automatic test_backpressure();
    rr = 1'b0;
    send(BR_BLTU, 32'h204, 32'h10, 1'b0, 32'd1, 32'd2);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (rv !== 1'b1) begin n_err++; $display("FAIL bp_rv[%0d]: got %b want 1", k, rv); end
      n_cmp++; if (flush_out !== (k == 0)) begin n_err++; $display("FAIL bp_flush[%0d]: got %b want %b", k, flush_out, k == 0); end
      n_cmp++; if (rpc !== 32'h214) begin n_err++; $display("FAIL bp_rpc[%0d]: got %h want 214", k, rpc); end
      n_cmp++; if (br_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", k, br_ready); end
      if (k == 3) rr = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (rv !== 1'b0 || br_ready !== 1'b1) begin n_err++; $display("FAIL bp_exit: got rv=%b rdy=%b want 0/1", rv, br_ready); end
    n_cmp++; if (mis_cnt !== 32'd2 || br_cnt !== 32'd2) begin n_err++; $display("FAIL bp_cnt: got %0d/%0d want 2/2", mis_cnt, br_cnt); end
  endtask

  task automatic test_wrap();
    send(BR_BNE, 32'hFFFF_FFFC, 32'd8, 1'b1, 32'd1, 32'd2);
    @(negedge clk);
    n_cmp++; if (rv !== 1'b0 || flush_out !== 1'b0) begin n_err++; $display("FAIL wr_noredir: got rv=%b fl=%b want 0/0", rv, flush_out); end
    n_cmp++; if (br_ready !== 1'b1) begin n_err++; $display("FAIL wr_idle: got %b want 1", br_ready); end
    n_cmp++; if (br_cnt !== 32'd3 || mis_cnt !== 32'd2) begin n_err++; $display("FAIL wr_cnt1: got %0d/%0d want 3/2", br_cnt, mis_cnt); end
    send(BR_BNE, 32'hFFFF_FFFC, 32'd8, 1'b0, 32'd1, 32'd2);
    @(negedge clk);
    n_cmp++; if (rv !== 1'b1) begin n_err++; $display("FAIL wr_rv: got %b want 1", rv); end
    n_cmp++; if (rpc !== 32'h4) begin n_err++; $display("FAIL wr_rpc: got %h want 4", rpc); end
    @(negedge clk);
    n_cmp++; if (br_cnt !== 32'd4 || mis_cnt !== 32'd3) begin n_err++; $display("FAIL wr_cnt2: got %0d/%0d want 4/3", br_cnt, mis_cnt); end
  endtask

  task automatic test_bht_sat();
    logic [7:0] exp_before, exp_after;
    logic       tk;
    exp_before = 8'b0011_1110;
    exp_after  = 8'b0001_1111;
    lookup_pc  = 32'h20;
    for (int i = 0; i < 8; i++) begin
      tk = (i < 4);
      send(BR_BGE, 32'h20, 32'h100, tk, tk ? 32'd5 : 32'd3, tk ? 32'd3 : 32'd5);
      n_cmp++; if (lookup_taken !== exp_before[i]) begin n_err++; $display("FAIL bht_pre[%0d]: got %b want %b", i, lookup_taken, exp_before[i]); end
      @(negedge clk);
      n_cmp++; if (lookup_taken !== exp_after[i]) begin n_err++; $display("FAIL bht_post[%0d]: got %b want %b", i, lookup_taken, exp_after[i]); end
      n_cmp++; if (rv !== 1'b0) begin n_err++; $display("FAIL bht_rv[%0d]: got %b want 0", i, rv); end
    end
    n_cmp++; if (br_cnt !== 32'd12 || mis_cnt !== 32'd3) begin n_err++; $display("FAIL bht_cnt: got %0d/%0d want 12/3", br_cnt, mis_cnt); end
  endtask

  task automatic test_flush();
    rr = 1'b1; lookup_pc = 32'h48;
    send(BR_BEQ, 32'h48, 32'h20, 1'b0, 32'd7, 32'd7);
    flush_in = 1'b1;
    #1;
    n_cmp++; if (br_ready !== 1'b0) begin n_err++; $display("FAIL fe_ready: got %b want 0", br_ready); end
    @(negedge clk); flush_in = 1'b0;
    #1;
    n_cmp++; if (rv !== 1'b0 || flush_out !== 1'b0) begin n_err++; $display("FAIL fe_noredir: got rv=%b fl=%b want 0/0", rv, flush_out); end
    n_cmp++; if (br_cnt !== 32'd12 || mis_cnt !== 32'd3) begin n_err++; $display("FAIL fe_cnt: got %0d/%0d want 12/3", br_cnt, mis_cnt); end
    n_cmp++; if (lookup_taken !== 1'b0) begin n_err++; $display("FAIL fe_bht: got %b want 0", lookup_taken); end
    n_cmp++; if (br_ready !== 1'b1) begin n_err++; $display("FAIL fe_idle: got %b want 1", br_ready); end
    @(negedge clk);
    rr = 1'b0;
    send(BR_BEQ, 32'h4C, 32'h20, 1'b0, 32'd7, 32'd7);
    @(negedge clk);
    n_cmp++; if (rv !== 1'b1 || flush_out !== 1'b1) begin n_err++; $display("FAIL fr_pre: got rv=%b fl=%b want 1/1", rv, flush_out); end
    n_cmp++; if (rpc !== 32'h6C) begin n_err++; $display("FAIL fr_rpc: got %h want 6c", rpc); end
    flush_in = 1'b1;
    #1;
    n_cmp++; if (flush_out !== 1'b0) begin n_err++; $display("FAIL fr_flush_o: got %b want 0", flush_out); end
    @(negedge clk); flush_in = 1'b0;
    #1;
    n_cmp++; if (rv !== 1'b0) begin n_err++; $display("FAIL fr_drop: got %b want 0", rv); end
    n_cmp++; if (br_cnt !== 32'd13 || mis_cnt !== 32'd4) begin n_err++; $display("FAIL fr_cnt: got %0d/%0d want 13/4", br_cnt, mis_cnt); end
    rr = 1'b1;
    @(negedge clk);
    flush_in = 1'b1; br_valid = 1'b1; br_op = BR_BEQ; br_pc = 32'h48; br_pred = 1'b0; rs1 = 32'd7; rs2 = 32'd7;
    #1;
    n_cmp++; if (br_ready !== 1'b0) begin n_err++; $display("FAIL fi_ready: got %b want 0", br_ready); end
    @(negedge clk); br_valid = 1'b0; flush_in = 1'b0;
    @(negedge clk);
    n_cmp++; if (br_cnt !== 32'd13 || rv !== 1'b0) begin n_err++; $display("FAIL fi_noaccept: got br=%0d rv=%b want 13/0", br_cnt, rv); end
  endtask

  task automatic test_undef_op();
    rr = 1'b1; lookup_pc = 32'h50;
    send(branch_op_e'(3'b010), 32'h50, 32'h100, 1'b1, 32'd9, 32'd9);
    @(negedge clk);
    n_cmp++; if (rv !== 1'b1) begin n_err++; $display("FAIL ud_rv: got %b want 1", rv); end
    n_cmp++; if (rpc !== 32'h54) begin n_err++; $display("FAIL ud_rpc: got %h want 54", rpc); end
    n_cmp++; if (br_cnt !== 32'd14 || mis_cnt !== 32'd5) begin n_err++; $display("FAIL ud_cnt: got %0d/%0d want 14/5", br_cnt, mis_cnt); end
    n_cmp++; if (lookup_taken !== 1'b0) begin n_err++; $display("FAIL ud_bht: got %b want 0", lookup_taken); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    rr = 1'b0; lookup_pc = 32'hFFFF_FFFC;
    send(BR_BEQ, 32'h100, 32'h8, 1'b0, 32'd1, 32'd1);
    @(negedge clk);
    n_cmp++; if (rv !== 1'b1 || lookup_taken !== 1'b1) begin n_err++; $display("FAIL rm_pre: got rv=%b lk=%b want 1/1", rv, lookup_taken); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rv !== 1'b0 || flush_out !== 1'b0) begin n_err++; $display("FAIL rm_rv: got rv=%b fl=%b want 0/0", rv, flush_out); end
    n_cmp++; if (br_cnt !== 32'd0 || mis_cnt !== 32'd0) begin n_err++; $display("FAIL rm_cnt: got %0d/%0d want 0/0", br_cnt, mis_cnt); end
    n_cmp++; if (br_ready !== 1'b1 || rpc !== 32'd0) begin n_err++; $display("FAIL rm_state: got rdy=%b rpc=%h want 1/0", br_ready, rpc); end
    n_cmp++; if (lookup_taken !== 1'b0) begin n_err++; $display("FAIL rm_bht: got %b want 0", lookup_taken); end
    @(negedge clk); rst_n = 1'b1; rr = 1'b1;
    @(negedge clk);
    n_cmp++; if (rv !== 1'b0) begin n_err++; $display("FAIL rm_after: got %b want 0", rv); end
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_backpressure();
    test_wrap();
    test_bht_sat();
    test_flush();
    test_undef_op();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
